elastic_pipelined_alu: RTL and testbench
========================================

# elastic_pipelined_alu

Elastic ALU with parametrised data width, per-opcode latency and an output FIFO, so a processing element accepts a new token while earlier results wait on a stalled consumer. It sits between the PE input-join logic and the output router/context switcher, using the same valid/stop (SELF) handshake on both sides. One operation is in flight at a time; up to OUT_DEPTH completed results are buffered.

## Interface
- DATA_WIDTH, 32: operand/result width
- ADDRESS_WIDTH, 16: memory address width, ≤ DATA_WIDTH
- OP_WIDTH, 4: opcode width
- OUT_DEPTH, 2: output FIFO depth, ≥ 1
- MUL_CYCLE, 2 / DIV_CYCLE, 4: latency of mul/div, ≥ 1; every other op is fixed at 1, except load, which is fixed at 2
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- input_data_1, input_data_2  in  DATA_WIDTH  operands
- op  in  OP_WIDTH  opcode, sampled at accept
- const_data  in  DATA_WIDTH  constant for op 5, sampled at accept
- memory_read_address  out  ADDRESS_WIDTH  load address
- memory_read_data  in  DATA_WIDTH  synchronous read data, valid 1 cycle after address
- valid_input  in  1  upstream token valid
- stop_input  out  1  stall upstream
- output_data  out  DATA_WIDTH  FIFO head
- valid_output  out  1  FIFO non-empty
- stop_output  in  1  downstream stall
- switch_context  out  1  one-cycle pulse per output transfer

## Operation
- Opcodes:
  - 0 nop → 0
  - 1 add, 2 sub, 3 mul: low DATA_WIDTH bits, wrap-around
  - 4 div: unsigned; divisor 0 → all-ones
  - 5 const → const_data
  - 6 load → memory_read_data at input_data_1[ADDRESS_WIDTH-1:0]
  - 7 output, 8 route → input_data_1
  - 9–15 → 0, latency 1
- accept = valid_input & !stop_input; push = result completes; pop = valid_output & !stop_output.
- Operands, op and const_data are registered at accept; later input changes do not affect the op in flight.
- States:
  - IDLE: accepts. Latency-1 op → push at the accept edge, stay IDLE. Otherwise → EXEC with counter = latency−1.
  - EXEC: counter decrements each cycle; when counter is 1, push at that edge and → IDLE.
- stop_input = (state==EXEC) | (count==OUT_DEPTH). It depends only on registered state, never combinationally on valid_input or stop_output.
- Load: memory_read_address is driven from the accept edge and held until the next accept. Data is captured at the EXEC edge.
- FIFO:
  - Simultaneous push and pop is allowed at any count, including full; count is unchanged.
  - Pop on empty cannot occur.
  - Order is strict FIFO.
- switch_context = pop.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; counter 0. Reset mid-EXEC discards the op in flight and all buffered results.
- Latency from accept edge to valid_output: 1 cycle for latency-1 ops, N cycles for N-cycle ops (FIFO empty, no stall).
- Throughput: one token per cycle for latency-1 ops while the FIFO is not full; one per N cycles otherwise.
- Full FIFO with pop in cycle t: stop_input falls in cycle t+1, not t.
- output_data is stable while valid_output & stop_output.

## Configuration
- ELASTIC_ALU_DIV_EN defined: op 4 is the divider with DIV_CYCLE latency, as above.
- ELASTIC_ALU_DIV_EN undefined: no divider is instantiated; op 4 yields 0 with latency 1 and DIV_CYCLE is ignored.

## Test plan
- Back-to-back add 3+4, 10+(−1), stop_output=0 → outputs 7, 9 on consecutive cycles; stop_input stays 0; two switch_context pulses.
- mul 6×7, MUL_CYCLE=2 → stop_input high 1 cycle; valid_output 2 cycles after accept with 42; wrap check 0xFFFFFFFF×2 → 0xFFFFFFFE.
- stop_output=1, three adds with OUT_DEPTH=2 → third held; stop_input=1; release → results in order, third accepted the cycle after the first pop.
- load at address 0x0010, memory returns 0xABCD → output 0xABCD at 2-cycle latency; memory_read_address=0x0010 from the accept edge.
- div 100/7 → 14; 5/0 → 0xFFFFFFFF (with ELASTIC_ALU_DIV_EN); without the macro 100/7 → 0 at latency 1.
- Assert reset_n mid-div with the FIFO holding 1 result → valid_output=0, stop_input=0, no switch_context afterwards.

Source files
------------

// File: rtl/elastic_pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipelined_alu
// Summary  : Valid/stop elastic ALU, per-opcode latency, output result FIFO.
//            Define ELASTIC_ALU_DIV_EN to build the multi-cycle divider (op 4).
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipelined_alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int OP_WIDTH      = 4,
    parameter int OUT_DEPTH     = 2,
    parameter int MUL_CYCLE     = 2,
    parameter int DIV_CYCLE     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    input_data_1,
    input  logic [DATA_WIDTH-1:0]    input_data_2,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic [DATA_WIDTH-1:0]    const_data,
    output logic [ADDRESS_WIDTH-1:0] memory_read_address,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    input  logic                     valid_input,
    output logic                     stop_input,
    output logic [DATA_WIDTH-1:0]    output_data,
    output logic                     valid_output,
    input  logic                     stop_output,
    output logic                     switch_context
);

    localparam logic [OP_WIDTH-1:0] c_OP_ADD   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] c_OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] c_OP_MUL   = OP_WIDTH'(3);
`ifdef ELASTIC_ALU_DIV_EN
    localparam logic [OP_WIDTH-1:0] c_OP_DIV   = OP_WIDTH'(4);
`endif
    localparam logic [OP_WIDTH-1:0] c_OP_CONST = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_OP_LOAD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] c_OP_OUT   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] c_OP_ROUTE = OP_WIDTH'(8);

    localparam int c_LAT_BASE = (MUL_CYCLE > 2) ? MUL_CYCLE : 2;
`ifdef ELASTIC_ALU_DIV_EN
    localparam int c_MAX_LAT  = (DIV_CYCLE > c_LAT_BASE) ? DIV_CYCLE : c_LAT_BASE;
`else
    // DIV_CYCLE is accepted but has no effect without the divider.
    localparam int c_MAX_LAT  = c_LAT_BASE + (DIV_CYCLE - DIV_CYCLE);
`endif
    localparam int c_CNT_W    = $clog2(c_MAX_LAT + 1);
    localparam int c_PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_FCNT_W   = $clog2(OUT_DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_CNT_W-1:0]      w_lat_in;
    logic [OP_WIDTH-1:0]     r_op;
    logic [DATA_WIDTH-1:0]   r_opa;
    logic [DATA_WIDTH-1:0]   r_opb;
    logic [DATA_WIDTH-1:0]   r_const;
    logic [ADDRESS_WIDTH-1:0] r_addr;

    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic [DATA_WIDTH-1:0]   w_push_data;

    logic [DATA_WIDTH-1:0]   r_mem [OUT_DEPTH];
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_FCNT_W-1:0]     r_count;

    function automatic logic [c_CNT_W-1:0] op_latency(input logic [OP_WIDTH-1:0] o);
        case (o)
            c_OP_MUL:  op_latency = c_CNT_W'(MUL_CYCLE);
`ifdef ELASTIC_ALU_DIV_EN
            c_OP_DIV:  op_latency = c_CNT_W'(DIV_CYCLE);
`endif
            c_OP_LOAD: op_latency = c_CNT_W'(2);
            default:   op_latency = c_CNT_W'(1);
        endcase
    endfunction

    // Load data is not produced here; it comes straight from memory_read_data.
    function automatic logic [DATA_WIDTH-1:0] alu_result(
        input logic [OP_WIDTH-1:0]   o,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] c
    );
        case (o)
            c_OP_ADD:             alu_result = a + b;
            c_OP_SUB:             alu_result = a - b;
            c_OP_MUL:             alu_result = a * b;
`ifdef ELASTIC_ALU_DIV_EN
            c_OP_DIV:             alu_result = (b == '0) ? '1 : a / b;
`endif
            c_OP_CONST:           alu_result = c;
            c_OP_OUT, c_OP_ROUTE: alu_result = a;
            default:              alu_result = '0;
        endcase
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        ptr_inc = (p == c_PTR_W'(OUT_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_full         = (r_count == c_FCNT_W'(OUT_DEPTH));
    assign stop_input     = (r_state == S_EXEC) | w_full;
    assign w_accept       = valid_input & ~stop_input;
    assign valid_output   = (r_count != '0);
    assign w_pop          = valid_output & ~stop_output;
    assign switch_context = w_pop;
    assign output_data    = valid_output ? r_mem[r_rd_ptr] : '0;

    // Address is presented in the accept cycle so the synchronous memory
    // latches it at the accept edge; the register then holds it afterwards.
    assign memory_read_address = w_accept ? input_data_1[ADDRESS_WIDTH-1:0] : r_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_push_data = '0;
        w_lat_in    = op_latency(op);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_lat_in == c_CNT_W'(1)) begin
                        w_push      = 1'b1;
                        w_push_data = alu_result(op, input_data_1, input_data_2, const_data);
                    end else begin
                        w_state_nxt = S_EXEC;
                        w_cnt_nxt   = w_lat_in - c_CNT_W'(1);
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_push      = 1'b1;
                    w_push_data = (r_op == c_OP_LOAD) ? memory_read_data
                                                      : alu_result(r_op, r_opa, r_opb, r_const);
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_const <= '0;
            r_addr  <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_opa   <= input_data_1;
            r_opb   <= input_data_2;
            r_const <= const_data;
            r_addr  <= input_data_1[ADDRESS_WIDTH-1:0];
        end
    end

    // Storage needs no reset: output_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FCNT_W'(1);
                2'b01:   r_count <= r_count - c_FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipelined_alu.sv
`default_nettype none
// Self-checking bench for elastic_pipelined_alu: directed scenarios plus a
// randomized phase, results scored against a queue-based reference model.
module tb_elastic_pipelined_alu;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int OW    = 4;
    localparam int DEPTH = 2;
    localparam int MULC  = 2;
    localparam int DIVC  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] input_data_1 = '0;
    logic [DW-1:0] input_data_2 = '0;
    logic [OW-1:0] op = '0;
    logic [DW-1:0] const_data = '0;
    logic [AW-1:0] memory_read_address;
    logic [DW-1:0] memory_read_data = '0;
    logic          valid_input = 1'b0;
    logic          stop_input;
    logic [DW-1:0] output_data;
    logic          valid_output;
    logic          stop_output = 1'b0;
    logic          switch_context;

    elastic_pipelined_alu #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .OP_WIDTH      (OW),
        .OUT_DEPTH     (DEPTH),
        .MUL_CYCLE     (MULC),
        .DIV_CYCLE     (DIVC)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .input_data_1        (input_data_1),
        .input_data_2        (input_data_2),
        .op                  (op),
        .const_data          (const_data),
        .memory_read_address (memory_read_address),
        .memory_read_data    (memory_read_data),
        .valid_input         (valid_input),
        .stop_input          (stop_input),
        .output_data         (output_data),
        .valid_output        (valid_output),
        .stop_output         (stop_output),
        .switch_context      (switch_context)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            sc_count = 0;
    logic [DW-1:0] exp_q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          rand_done  = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0010) return 32'h0000ABCD;
        return {a ^ 16'h5A5A, a};
    endfunction

    // Synchronous-read memory: address seen at an edge, data valid after it.
    always @(posedge clk) memory_read_data <= mem_word(memory_read_address);

    function automatic logic [DW-1:0] model(input logic [OW-1:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] c);
        case (o)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a * b;
`ifdef ELASTIC_ALU_DIV_EN
            4'd4: return (b == 0) ? {DW{1'b1}} : a / b;
`endif
            4'd5: return c;
            4'd6: return mem_word(a[AW-1:0]);
            4'd7, 4'd8: return a;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a token, wait for acceptance, then scramble the operands.
    task automatic drive(input logic [OW-1:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c);
        int t = 0;
        valid_input  = 1'b1;
        op           = o;
        input_data_1 = a;
        input_data_2 = b;
        const_data   = c;
        while (stop_input && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) fail_event("accept_timeout");
        else exp_q.push_back(model(o, a, b, c));
        tick();
        valid_input  = 1'b0;
        op           = OW'($urandom);
        input_data_1 = $urandom;
        input_data_2 = $urandom;
        const_data   = $urandom;
    endtask

    task automatic measure(input string name, input int n);
        int k  = 1;
        int hi = 0;
        while (!valid_output && k < 40) begin
            if (stop_input) hi++;
            tick();
            k++;
        end
        check({name, "_latency"}, k, n);
        check({name, "_stop_cycles"}, hi, n - 1);
    endtask

    task automatic wait_empty();
        int k = 0;
        while ((valid_output || stop_input) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) fail_event("drain_timeout");
        tick();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", valid_output, 1'b1);
                    check("hold_data", output_data, prev_data);
                end
                check("switch_context", switch_context, valid_output & ~stop_output);
                if (switch_context) sc_count++;
                if (valid_output && !stop_output) begin
                    if (exp_q.size() == 0) fail_event("spurious_output");
                    else check("result", output_data, exp_q.pop_front());
                end
                prev_stall = valid_output & stop_output;
                prev_data  = output_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sc0;
        repeat (3) tick();
        check("rst_valid_output", valid_output, 1'b0);
        check("rst_stop_input", stop_input, 1'b0);
        check("rst_output_data", output_data, '0);
        check("rst_switch_context", switch_context, 1'b0);
        check("rst_mem_addr", memory_read_address, '0);
        reset_n = 1'b1;
        tick();

        // Back-to-back latency-1 adds
        sc0 = sc_count;
        drive(4'd1, 32'd3, 32'd4, '0);
        check("add1_valid", valid_output, 1'b1);
        check("add1_stop_input", stop_input, 1'b0);
        drive(4'd1, 32'd10, 32'hFFFF_FFFF, '0);
        check("add2_stop_input", stop_input, 1'b0);
        tick();
        tick();
        check("b2b_pulses", sc_count - sc0, 2);

        // Multiply with latency and wrap-around
        wait_empty();
        drive(4'd3, 32'd6, 32'd7, '0);
        measure("mul", MULC);
        wait_empty();
        drive(4'd3, 32'hFFFF_FFFF, 32'd2, '0);
        measure("mul_wrap", MULC);

        // Full FIFO with stalled consumer, then release
        wait_empty();
        stop_output = 1'b1;
        drive(4'd1, 32'd1, 32'd1, '0);
        drive(4'd1, 32'd2, 32'd2, '0);
        fork
            drive(4'd1, 32'd3, 32'd3, '0);
            begin
                repeat (3) tick();
                check("full_stop_input", stop_input, 1'b1);
                check("full_valid", valid_output, 1'b1);
                stop_output = 1'b0;
                check("pop_cycle_stop_input", stop_input, 1'b1);
                tick();
                check("after_pop_stop_input", stop_input, 1'b0);
            end
        join

        // Load
        wait_empty();
        drive(4'd6, 32'h0000_0010, '0, '0);
        check("load_addr", memory_read_address, 16'h0010);
        measure("load", 2);
        check("load_addr_hold", memory_read_address, 16'h0010);

        // Divide
        wait_empty();
`ifdef ELASTIC_ALU_DIV_EN
        drive(4'd4, 32'd100, 32'd7, '0);
        measure("div", DIVC);
        wait_empty();
        drive(4'd4, 32'd5, 32'd0, '0);
        measure("div0", DIVC);
`else
        drive(4'd4, 32'd100, 32'd7, '0);
        measure("div_off", 1);
`endif

        // Reset in the middle of a multi-cycle op with one buffered result
        wait_empty();
        stop_output = 1'b1;
        drive(4'd1, 32'd20, 32'd22, '0);
`ifdef ELASTIC_ALU_DIV_EN
        drive(4'd4, 32'd1000, 32'd10, '0);
`else
        drive(4'd3, 32'd5, 32'd5, '0);
`endif
        reset_n = 1'b0;
        tick();
        check("midrst_valid_output", valid_output, 1'b0);
        check("midrst_stop_input", stop_input, 1'b0);
        check("midrst_switch_context", switch_context, 1'b0);
        reset_n     = 1'b1;
        stop_output = 1'b0;
        sc0 = sc_count;
        repeat (6) tick();
        check("postrst_pulses", sc_count - sc0, 0);
        check("postrst_valid_output", valid_output, 1'b0);

        // Randomized traffic with random downstream stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [OW-1:0] ro;
                    logic [DW-1:0] rb;
                    ro = OW'($urandom_range(0, 15));
                    rb = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom);
                    if ($urandom_range(0, 3) == 0) tick();
                    drive(ro, $urandom, rb, $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    stop_output = ($urandom_range(0, 99) < 40);
                end
            end
        join
        stop_output = 1'b0;
        wait_empty();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
